// File: rtl/wb_fifo.sv
// Dual-pipe writeback buffer: one in-order result FIFO per exec pipe.
// Heads drain onto registered writeback ports; same-address head collisions pop A first.
package wb_fifo_pkg;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned VAL_W  = 16;
  localparam int unsigned STAT_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [VAL_W-1:0]  val;
    logic [STAT_W-1:0] status;
  } wb_entry_t;
endpackage

module wb_fifo_pipe
  import wb_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head_c,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             overflow,
  output logic             wb,
  output wb_entry_t        wb_entry
);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign accept = push && ((count != CNT_W'(DEPTH)) || pop);
  assign full   = (count == CNT_W'(DEPTH));
  assign head_c = mem[rd_ptr];

  // Payload storage carries no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wb       <= 1'b0;
      wb_entry <= '0;
    end else begin
      wb <= pop;
      if (pop) begin
        wb_entry <= head_c;
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (push && !accept) overflow <= 1'b1;
      if (accept && !pop)      count <= count + CNT_W'(1);
      else if (!accept && pop) count <= count - CNT_W'(1);
    end
  end
endmodule

module wb_fifo
  import wb_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             pushA_i,
  input  logic             pushB_i,
  input  logic [4:0]       pushAddrA_i,
  input  logic [4:0]       pushAddrB_i,
  input  logic [15:0]      pushValA_i,
  input  logic [15:0]      pushValB_i,
  input  logic [1:0]       pushStatusA_i,
  input  logic [1:0]       pushStatusB_i,
  input  logic             drainHold_i,
  output logic             fullA_o,
  output logic             fullB_o,
  output logic [PTR_W:0]   countA_o,
  output logic [PTR_W:0]   countB_o,
  output logic             overflowA_o,
  output logic             overflowB_o,
  output logic             wbA_o,
  output logic             wbB_o,
  output logic [4:0]       wbAddrA_o,
  output logic [4:0]       wbAddrB_o,
  output logic [15:0]      wbValA_o,
  output logic [15:0]      wbValB_o,
  output logic [1:0]       operationStatusA_o,
  output logic [1:0]       operationStatusB_o
);
  wb_entry_t push_entry_a, push_entry_b;
  wb_entry_t head_a, head_b;
  wb_entry_t wb_entry_a, wb_entry_b;
  logic      elig_a, elig_b, collide, pop_a, pop_b;

  assign push_entry_a = '{addr: pushAddrA_i, val: pushValA_i, status: pushStatusA_i};
  assign push_entry_b = '{addr: pushAddrB_i, val: pushValB_i, status: pushStatusB_i};

  // Same-address heads: A goes first so B's later write wins in the register file.
  assign elig_a  = (countA_o != '0) && !drainHold_i;
  assign elig_b  = (countB_o != '0) && !drainHold_i;
  assign collide = elig_a && elig_b && (head_a.addr == head_b.addr);
  assign pop_a   = elig_a;
  assign pop_b   = elig_b && !collide;

  wb_fifo_pipe #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_pipe_a (
    .clk        (clock_i),
    .rst_n      (reset_i),
    .push       (pushA_i),
    .push_entry (push_entry_a),
    .pop        (pop_a),
    .head_c     (head_a),
    .count      (countA_o),
    .full       (fullA_o),
    .overflow   (overflowA_o),
    .wb         (wbA_o),
    .wb_entry   (wb_entry_a)
  );

  wb_fifo_pipe #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_pipe_b (
    .clk        (clock_i),
    .rst_n      (reset_i),
    .push       (pushB_i),
    .push_entry (push_entry_b),
    .pop        (pop_b),
    .head_c     (head_b),
    .count      (countB_o),
    .full       (fullB_o),
    .overflow   (overflowB_o),
    .wb         (wbB_o),
    .wb_entry   (wb_entry_b)
  );

  assign wbAddrA_o          = wb_entry_a.addr;
  assign wbValA_o           = wb_entry_a.val;
  assign operationStatusA_o = wb_entry_a.status;
  assign wbAddrB_o          = wb_entry_b.addr;
  assign wbValB_o           = wb_entry_b.val;
  assign operationStatusB_o = wb_entry_b.status;
endmodule

// File: tb/tb_wb_fifo.sv
// Bench for wb_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_wb_fifo;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] val;
    logic [1:0]  st;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pushA_i, pushB_i, drainHold_i;
  logic [4:0]  pushAddrA_i, pushAddrB_i;
  logic [15:0] pushValA_i, pushValB_i;
  logic [1:0]  pushStatusA_i, pushStatusB_i;
  logic        fullA_o, fullB_o, overflowA_o, overflowB_o, wbA_o, wbB_o;
  logic [PTR_W:0] countA_o, countB_o;
  logic [4:0]  wbAddrA_o, wbAddrB_o;
  logic [15:0] wbValA_o, wbValB_o;
  logic [1:0]  operationStatusA_o, operationStatusB_o;

  int tests = 0;
  int fails = 0;

  ent_t qa[$];
  ent_t qb[$];
  ent_t exp_a, exp_b;
  logic exp_wb_a, exp_wb_b, exp_ovf_a, exp_ovf_b;

  wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock_i(clk), .reset_i(rst_n),
    .pushA_i(pushA_i), .pushB_i(pushB_i),
    .pushAddrA_i(pushAddrA_i), .pushAddrB_i(pushAddrB_i),
    .pushValA_i(pushValA_i), .pushValB_i(pushValB_i),
    .pushStatusA_i(pushStatusA_i), .pushStatusB_i(pushStatusB_i),
    .drainHold_i(drainHold_i),
    .fullA_o(fullA_o), .fullB_o(fullB_o),
    .countA_o(countA_o), .countB_o(countB_o),
    .overflowA_o(overflowA_o), .overflowB_o(overflowB_o),
    .wbA_o(wbA_o), .wbB_o(wbB_o),
    .wbAddrA_o(wbAddrA_o), .wbAddrB_o(wbAddrB_o),
    .wbValA_o(wbValA_o), .wbValB_o(wbValB_o),
    .operationStatusA_o(operationStatusA_o), .operationStatusB_o(operationStatusB_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    exp_a = '0; exp_b = '0;
    exp_wb_a = 1'b0; exp_wb_b = 1'b0;
    exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
  endtask

  // Behaviour at one rising edge, from the current (stable) inputs.
  task automatic model_edge();
    bit pa, pb;
    pa = (qa.size() > 0) && !drainHold_i;
    pb = (qb.size() > 0) && !drainHold_i;
    if (pa && pb && (qa[0].addr == qb[0].addr)) pb = 1'b0;
    exp_wb_a = pa;
    exp_wb_b = pb;
    if (pa) exp_a = qa.pop_front();
    if (pb) exp_b = qb.pop_front();
    if (pushA_i) begin
      if (qa.size() < DEPTH) qa.push_back('{addr: pushAddrA_i, val: pushValA_i, st: pushStatusA_i});
      else exp_ovf_a = 1'b1;
    end
    if (pushB_i) begin
      if (qb.size() < DEPTH) qb.push_back('{addr: pushAddrB_i, val: pushValB_i, st: pushStatusB_i});
      else exp_ovf_b = 1'b1;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".wbA"},    32'(wbA_o), 32'(exp_wb_a));
    chk({ph, ".addrA"},  32'(wbAddrA_o), 32'(exp_a.addr));
    chk({ph, ".valA"},   32'(wbValA_o), 32'(exp_a.val));
    chk({ph, ".stA"},    32'(operationStatusA_o), 32'(exp_a.st));
    chk({ph, ".cntA"},   32'(countA_o), 32'(qa.size()));
    chk({ph, ".fullA"},  32'(fullA_o), 32'(qa.size() == DEPTH));
    chk({ph, ".ovfA"},   32'(overflowA_o), 32'(exp_ovf_a));
    chk({ph, ".wbB"},    32'(wbB_o), 32'(exp_wb_b));
    chk({ph, ".addrB"},  32'(wbAddrB_o), 32'(exp_b.addr));
    chk({ph, ".valB"},   32'(wbValB_o), 32'(exp_b.val));
    chk({ph, ".stB"},    32'(operationStatusB_o), 32'(exp_b.st));
    chk({ph, ".cntB"},   32'(countB_o), 32'(qb.size()));
    chk({ph, ".fullB"},  32'(fullB_o), 32'(qb.size() == DEPTH));
    chk({ph, ".ovfB"},   32'(overflowB_o), 32'(exp_ovf_b));
  endtask

  task automatic drive(input logic pa, input logic [4:0] aa, input logic [15:0] va, input logic [1:0] sa,
                       input logic pb, input logic [4:0] ab, input logic [15:0] vb, input logic [1:0] sb,
                       input logic hold);
    pushA_i = pa; pushAddrA_i = aa; pushValA_i = va; pushStatusA_i = sa;
    pushB_i = pb; pushAddrB_i = ab; pushValB_i = vb; pushStatusB_i = sb;
    drainHold_i = hold;
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    #1;
    model_edge();
    check_all(ph);
  endtask

  task automatic idle(input logic hold);
    drive(1'b0, 5'd0, 16'd0, 2'd0, 1'b0, 5'd0, 16'd0, 2'd0, hold);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Single push into A, one cycle of storage before the strobe.
    drive(1'b1, 5'd5, 16'h1234, 2'b01, 1'b0, 5'd0, 16'd0, 2'd0, 1'b0);
    step("sp_e1");
    idle(1'b0);
    step("sp_e2");
    chk("sp_wb", 32'(wbA_o), 32'd1);
    chk("sp_val", 32'(wbValA_o), 32'h1234);
    chk("sp_addr", 32'(wbAddrA_o), 32'd5);
    step("sp_e3");
    chk("sp_cnt", 32'(countA_o), 32'd0);

    // Overfill B under hold, then drain in order.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 5'd0, 16'd0, 2'd0, 1'b1, 5'(i + 10), 16'(16'h0B00 + i), 2'(i), 1'b1);
      step("ovf_fill");
    end
    chk("ovf_cntB", 32'(countB_o), 32'd8);
    chk("ovf_fullB", 32'(fullB_o), 32'd1);
    chk("ovf_flagB", 32'(overflowB_o), 32'd1);
    idle(1'b0);
    for (int i = 0; i < 10; i++) step("ovf_drain");
    chk("ovf_sticky", 32'(overflowB_o), 32'd1);
    chk("ovf_lastval", 32'(wbValB_o), 32'h0B07);

    // Same-address heads: A first, B the cycle after.
    drive(1'b1, 5'd7, 16'd1, 2'd0, 1'b1, 5'd7, 16'd2, 2'd0, 1'b1);
    step("col_load");
    idle(1'b0);
    step("col_n");
    chk("col_n_wbA", 32'(wbA_o), 32'd1);
    chk("col_n_valA", 32'(wbValA_o), 32'd1);
    chk("col_n_wbB", 32'(wbB_o), 32'd0);
    step("col_n1");
    chk("col_n1_wbB", 32'(wbB_o), 32'd1);
    chk("col_n1_valB", 32'(wbValB_o), 32'd2);
    step("col_end");

    // Fill A, then push and pop every cycle across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i), 16'(16'hA000 + i), 2'(i), 1'b0, 5'd0, 16'd0, 2'd0, 1'b1);
      step("wrap_fill");
    end
    for (int i = 8; i < 32; i++) begin
      drive(1'b1, 5'(i), 16'(16'hA000 + i), 2'(i), 1'b0, 5'd0, 16'd0, 2'd0, 1'b0);
      step("wrap_stream");
    end
    chk("wrap_cntA", 32'(countA_o), 32'd8);
    chk("wrap_ovfA", 32'(overflowA_o), 32'd0);
    idle(1'b0);
    for (int i = 0; i < 9; i++) step("wrap_drain");

    // Random traffic with a narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 3) == 0));
      step("rand");
    end
    idle(1'b0);
    for (int i = 0; i < 10; i++) step("rand_drain");

    // Mid-stream asynchronous reset with entries queued.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 20), 16'(16'hC000 + i), 2'd3, 1'b0, 5'd0, 16'd0, 2'd0, 1'b1);
      step("rst_fill");
    end
    chk("rst_pre_cnt", 32'(countA_o), 32'd4);
    idle(1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
